// File: rtl/alu_5output_if.sv
// rtl/alu_5output_if.sv - operand/select and result bundle for the 4-bit registered ALU
interface alu_5output_if;
   logic       S0;
   logic       S1;
   logic [3:0] A;
   logic [3:0] B;
   logic [3:0] Output;
   logic       carry;

   modport master (
      output S0,
      output S1,
      output A,
      output B,
      input  Output,
      input  carry
   );

   modport slave (
      input  S0,
      input  S1,
      input  A,
      input  B,
      output Output,
      output carry
   );
endinterface

// File: rtl/alu_5output.sv
// rtl/alu_5output.sv - 4-bit add/sub/and/or ALU with registered result and carry
module alu_5output (
   input  logic         clk,
   input  logic         rst_n,
   alu_5output_if.slave bus
);
   logic [3:0] result_d, result_q;
   logic       carry_d, carry_q;
   logic [4:0] sum;

   // SUB adds the one's complement plus one, so bit 4 reads as not-borrow
   always_comb begin
      sum      = 5'd0;
      result_d = 4'd0;
      carry_d  = 1'b0;
      unique case ({bus.S1, bus.S0})
         2'b00:   sum = {1'b0, bus.A} + {1'b0, bus.B};
         2'b01:   sum = {1'b0, bus.A} + {1'b0, ~bus.B} + 5'd1;
         2'b10:   sum = {1'b0, bus.A & bus.B};
         default: sum = {1'b0, bus.A | bus.B};
      endcase
      result_d = sum[3:0];
      carry_d  = sum[4];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= 4'd0;
         carry_q  <= 1'b0;
      end else begin
         result_q <= result_d;
         carry_q  <= carry_d;
      end
   end

   assign bus.Output = result_q;
   assign bus.carry  = carry_q;
endmodule

// File: tb/tb_alu_5output.sv
// tb/tb_alu_5output.sv - table-driven and scoreboard checks for alu_5output
module tb_alu_5output;
   logic clk;
   logic rst_n;

   alu_5output_if bus ();

   alu_5output dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [1:0] sel;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] eo;
      logic       ec;
   } vec_t;

   typedef struct {
      string      name;
      logic [3:0] eo;
      logic       ec;
   } exp_t;

   vec_t vecs [15];
   exp_t sb [$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [3:0] ao, input logic ac,
                        input logic [3:0] eo, input logic ec);
      n_cmp++;
      if (ao !== eo || ac !== ec) begin
         n_fail++;
         $display("FAIL %s: got Output=%b carry=%b, want Output=%b carry=%b", name, ao, ac, eo, ec);
      end
   endtask

   function automatic exp_t model(input string name, input logic [1:0] s,
                                  input logic [3:0] a, input logic [3:0] b);
      exp_t r;
      r.name = name;
      case (s)
         2'd0: begin r.eo = 4'((int'(a) + int'(b)) % 16); r.ec = (int'(a) + int'(b)) > 15; end
         2'd1: begin r.eo = 4'((int'(a) - int'(b) + 16) % 16); r.ec = (a >= b); end
         2'd2: begin r.eo = a & b; r.ec = 1'b0; end
         default: begin r.eo = a | b; r.ec = 1'b0; end
      endcase
      return r;
   endfunction

   task automatic drive(input logic [1:0] s, input logic [3:0] a, input logic [3:0] b);
      bus.S1 = s[1];
      bus.S0 = s[0];
      bus.A  = a;
      bus.B  = b;
   endtask

   // drive on the falling edge, push expectation, compare just after the rising edge
   task automatic apply(input string name, input logic [1:0] s, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] eo, input logic ec);
      exp_t e;
      @(negedge clk);
      drive(s, a, b);
      e.name = name; e.eo = eo; e.ec = ec;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_cmp++; n_fail++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         e = sb.pop_front();
         check(e.name, bus.Output, bus.carry, e.eo, e.ec);
      end
   endtask

   initial begin
      exp_t e;
      logic [1:0] rs;
      logic [3:0] ra, rb;

      vecs[0]  = '{2'b00, 4'b0101, 4'b1001, 4'b1110, 1'b0};
      vecs[1]  = '{2'b00, 4'b0000, 4'b1100, 4'b1100, 1'b0};
      vecs[2]  = '{2'b00, 4'b1111, 4'b0001, 4'b0000, 1'b1};
      vecs[3]  = '{2'b00, 4'b1111, 4'b1111, 4'b1110, 1'b1};
      vecs[4]  = '{2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0};
      vecs[5]  = '{2'b01, 4'b0100, 4'b1011, 4'b1001, 1'b0};
      vecs[6]  = '{2'b01, 4'b1001, 4'b0011, 4'b0110, 1'b1};
      vecs[7]  = '{2'b01, 4'b0111, 4'b0111, 4'b0000, 1'b1};
      vecs[8]  = '{2'b01, 4'b0000, 4'b0001, 4'b1111, 1'b0};
      vecs[9]  = '{2'b10, 4'b0110, 4'b1101, 4'b0100, 1'b0};
      vecs[10] = '{2'b10, 4'b1000, 4'b1000, 4'b1000, 1'b0};
      vecs[11] = '{2'b10, 4'b1011, 4'b1010, 4'b1010, 1'b0};
      vecs[12] = '{2'b11, 4'b0110, 4'b1111, 4'b1111, 1'b0};
      vecs[13] = '{2'b11, 4'b0101, 4'b1100, 4'b1101, 1'b0};
      vecs[14] = '{2'b11, 4'b0011, 4'b1100, 4'b1111, 1'b0};

      // reset held with busy random inputs
      rst_n = 1'b0;
      drive(2'b00, 4'hF, 4'hF);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         @(posedge clk);
         #1;
         check("reset_hold", bus.Output, bus.carry, 4'b0000, 1'b0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++)
         apply($sformatf("vec%0d", i), vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].eo, vecs[i].ec);

      // back-to-back random operations against the reference model
      for (int i = 0; i < 40; i++) begin
         rs = 2'($urandom_range(0, 3));
         ra = 4'($urandom_range(0, 15));
         rb = 4'($urandom_range(0, 15));
         e  = model($sformatf("b2b%0d", i), rs, ra, rb);
         apply(e.name, rs, ra, rb, e.eo, e.ec);
      end

      // inputs wiggled between edges must not reach the outputs
      apply("hold_load", 2'b00, 4'b0101, 4'b1001, 4'b1110, 1'b0);
      #2;
      drive(2'b10, 4'b0000, 4'b0000);
      #1;
      check("hold_mid1", bus.Output, bus.carry, 4'b1110, 1'b0);
      @(negedge clk);
      drive(2'b11, 4'b1111, 4'b1111);
      #3;
      check("hold_mid2", bus.Output, bus.carry, 4'b1110, 1'b0);
      @(posedge clk);
      #1;
      check("hold_next", bus.Output, bus.carry, 4'b1111, 1'b0);

      // asynchronous reset mid-cycle clears at once and drops the pending result
      apply("pre_rst", 2'b00, 4'b1111, 4'b1111, 4'b1110, 1'b1);
      #2;
      drive(2'b01, 4'b1001, 4'b0011);
      rst_n = 1'b0;
      #1;
      check("async_rst", bus.Output, bus.carry, 4'b0000, 1'b0);
      @(posedge clk);
      #1;
      check("rst_edge", bus.Output, bus.carry, 4'b0000, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_release", bus.Output, bus.carry, 4'b0000, 1'b0);
      @(posedge clk);
      #1;
      check("first_after_rst", bus.Output, bus.carry, 4'b0110, 1'b1);

      if (sb.size() != 0) begin
         n_cmp++; n_fail++;
         $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
